// File: rtl/wb_int_ctrl.sv
// Wishbone-attached INT0/NMI interrupt controller for the Tube parasite interface.
// Holds INT0 mask/mode/priority, tracks pending and in-service state, and forwards a latched NMI.
module wb_int_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        irq_b_i,
    input  logic        nmi_b_i,
    input  logic        inta_i,
    input  logic        nmia_i,
    output logic        intr_o,
    output logic        nmi_o,
    output logic [15:0] vec_o
);
    localparam logic [3:0] ADR_EOI    = 4'd1;   // 0xFF22
    localparam logic [3:0] ADR_MASK   = 4'd4;   // 0xFF28
    localparam logic [3:0] ADR_INSERV = 4'd6;   // 0xFF2C
    localparam logic [3:0] ADR_REQST  = 4'd7;   // 0xFF2E
    localparam logic [3:0] ADR_I0CON  = 4'd12;  // 0xFF38
    localparam logic [4:0] EOI_INT0   = 5'd12;

    logic [2:0]  pr;
    logic        msk;
    logic        ltm;
    logic        pending;
    logic        inservice;
    logic [2:0]  irq_sync;
    logic [2:0]  nmi_sync;
    logic        irq_rise;
    logic        inta_d;
    logic        nmi_held;
    logic        req;
    logic        wr;
    logic        eoi_clear;
    logic        inta_rise;
    logic        irq_edge;
    logic        nmi_edge;
    logic [15:0] rdata;
    logic        unused_dat;

    assign unused_dat = ^wb_dat_i[14:5];

    assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr  = wb_ack_o & wb_cyc_i & wb_stb_i & wb_we_i;

    always_comb begin
        rdata = 16'h0000;
        case (wb_adr_i)
            ADR_MASK:   rdata = {11'b0, msk, 4'b0};
            ADR_INSERV: rdata = {11'b0, inservice, 4'b0};
            ADR_REQST:  rdata = {11'b0, pending, 4'b0};
            ADR_I0CON:  rdata = {11'b0, ltm, msk, pr};
            default:    rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 16'h0000;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= req ? rdata : 16'h0000;
        end
    end

    // MASK bit4 and I0CON bit3 alias the same mask flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pr  <= 3'd7;
            msk <= 1'b1;
            ltm <= 1'b0;
        end else if (wr && wb_sel_i[0]) begin
            if (wb_adr_i == ADR_MASK) begin
                msk <= wb_dat_i[4];
            end else if (wb_adr_i == ADR_I0CON) begin
                pr  <= wb_dat_i[2:0];
                msk <= wb_dat_i[3];
                ltm <= wb_dat_i[4];
            end
        end
    end

    assign eoi_clear = wr && (wb_adr_i == ADR_EOI) &&
                       ((wb_sel_i[1] && wb_dat_i[15]) ||
                        (wb_sel_i[0] && (wb_dat_i[4:0] == EOI_INT0)));

    assign irq_edge  = irq_sync[1] & ~irq_sync[2];
    assign nmi_edge  = nmi_sync[1] & ~nmi_sync[2];
    assign inta_rise = inta_i & ~inta_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_sync <= 3'b000;
            nmi_sync <= 3'b000;
            irq_rise <= 1'b0;
            inta_d   <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[1:0], ~irq_b_i};
            nmi_sync <= {nmi_sync[1:0], ~nmi_b_i};
            irq_rise <= irq_edge;
            inta_d   <= inta_i;
        end
    end

    // A fresh edge beats an acknowledge in the same cycle, as does acknowledge over EOI.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            inservice <= 1'b0;
            intr_o    <= 1'b0;
        end else begin
            if (ltm)
                pending <= irq_sync[1];
            else if (irq_rise)
                pending <= 1'b1;
            else if (inta_rise)
                pending <= 1'b0;

            if (inta_rise)
                inservice <= 1'b1;
            else if (eoi_clear)
                inservice <= 1'b0;

            intr_o <= pending & ~msk & ~inservice;
        end
    end

    // An edge arriving while nmia_i is high is parked in nmi_held until the acknowledge ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_o    <= 1'b0;
            nmi_held <= 1'b0;
        end else if (nmia_i) begin
            nmi_o <= 1'b0;
            if (nmi_edge)
                nmi_held <= 1'b1;
        end else if (nmi_edge || nmi_held) begin
            nmi_o    <= 1'b1;
            nmi_held <= 1'b0;
        end
    end

    always_comb begin
        vec_o = 16'h0000;
        if (nmia_i)
            vec_o = 16'h0002;
        else if (inta_i)
            vec_o = 16'h000C;
    end
endmodule

// File: doc/wb_int_ctrl.md
WB_INT_CTRL -- requirements
Module: wb_int_ctrl

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone slave cycle, strobe and write-enable.
REQ-004 wb_adr_i  in  4  word address [4:1] within I/O window 0xFF20-0xFF3E.
REQ-005 wb_sel_i  in  2  byte lanes; bit0 = D[7:0], bit1 = D[15:8].
REQ-006 wb_dat_i  in  16  write data.
REQ-007 wb_dat_o  out  16  read data.
REQ-008 wb_ack_o  out  1  Wishbone acknowledge.
REQ-009 irq_b_i  in  1  Tube parasite IRQ, active-low, asynchronous to clk.
REQ-010 nmi_b_i  in  1  Tube parasite NMI, active-low, asynchronous to clk.
REQ-011 inta_i  in  1  CPU interrupt acknowledge (wb_tgc_o of CPU).
REQ-012 nmia_i  in  1  CPU NMI acknowledge.
REQ-013 intr_o  out  1  maskable interrupt request to CPU.
REQ-014 nmi_o  out  1  NMI request to CPU.
REQ-015 vec_o  out  16  vector returned during acknowledge: 0x0002 when nmia_i, else 0x000C when inta_i, else 0x0000.

Function
REQ-016 Registers: 0x22 EOI (write-only; reads 0x0000); 0x28 MASK (bit4 = INT0 mask); 0x2C INSERV (bit4, read-only); 0x2E REQST (bit4 = INT0 pending, read-only); 0x38 I0CON (bits[2:0] PR, bit3 MSK, bit4 LTM); all other offsets read 0x0000 and ignore writes.
REQ-017 MASK bit4 and I0CON bit3 are one flop; writing either updates it; both read back the same value.
REQ-018 Writes honour wb_sel_i per byte lane; unimplemented bits read 0.
REQ-019 wb_ack_o asserts exactly one cycle after the first cycle with wb_cyc_i & wb_stb_i & !wb_ack_o, stays high one cycle, then deasserts; register update occurs on the ack cycle.
REQ-020 wb_dat_o valid during the ack cycle.
REQ-021 irq_b_i and nmi_b_i each pass through a 2-flop synchroniser plus a third flop for edge detection.
REQ-022 INT0 edge mode (LTM=0): synchronised rising edge of ~irq_b_i sets pending; pending cleared on the first cycle of inta_i high.
REQ-023 INT0 level mode (LTM=1): pending follows synchronised ~irq_b_i each cycle.
REQ-024 intr_o = pending & !mask & !inservice, registered (one-cycle delay).
REQ-025 inservice sets on the first cycle of inta_i high (rising edge of inta_i); cleared by any EOI write with bit15 = 1 (non-specific) or bits[4:0] = 12 (specific INT0); other EOI values ignored.
REQ-026 Simultaneous new INT0 edge and inta_i rising edge in the same cycle: pending remains set.
REQ-027 Simultaneous inta_i rising edge and EOI write: inservice ends set.
REQ-028 NMI: synchronised rising edge of ~nmi_b_i sets nmi_o; nmi_o cleared while nmia_i high; a new edge in a cycle with nmia_i high is not lost (nmi_o set next cycle after nmia_i falls is acceptable only if edge was captured in a latch).
REQ-029 NMI is not maskable and does not affect INT0 state.
REQ-030 Latency from irq_b_i falling to intr_o high (edge mode, unmasked, idle): 5 clk cycles.

Reset
REQ-031 On rst: I0CON = 0x000F (masked, PR = 7, edge mode), pending = 0, inservice = 0, synchroniser flops = 0, intr_o = 0, nmi_o = 0, wb_ack_o = 0, wb_dat_o = 0x0000.
REQ-032 rst asserted mid-transaction drops wb_ack_o the next cycle; no register write is committed.

Verification
REQ-033 After reset read 0x38 -> 0x000F; read 0x28 -> 0x0010; irq_b_i pulsed low -> intr_o stays 0, REQST reads 0x0010.
REQ-034 Write 0x38 = 0x0007, pulse irq_b_i low -> intr_o high 5 cycles later; pulse inta_i -> vec_o = 0x000C, intr_o falls, INSERV reads 0x0010.
REQ-035 With INT0 in service, second irq edge -> intr_o stays 0; write EOI 0x8000 -> intr_o rises next-but-one cycle.
REQ-036 Drive nmi_b_i low -> nmi_o high after 3 cycles; assert nmia_i -> vec_o = 0x0002, nmi_o clears.
REQ-037 Write 0x38 = 0x0017 (level), hold irq_b_i low, EOI after each inta_i -> intr_o reasserts; release irq_b_i -> intr_o 0 within 4 cycles.
REQ-038 Byte write sel = 01 of 0x0008 to 0x38 -> MSK set, upper byte unchanged; wb_ack_o exactly one cycle per strobe.
